// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control unit with a memory request/ready
// handshake, bus-timeout watchdog, illegal-opcode trap and fetch stall.
// The shared datapath select typedefs live in mc_control_pkg below.

package mc_control_pkg;
    typedef enum logic       {ADDR_PC, ADDR_RESULT} mem_addr_sel_t;
    typedef enum logic       {FETCH_INST, MEM_FUNCT_DEFINED} mem_funct3_sel_t;
    typedef enum logic [1:0] {RS1V, PC, PC_OLD} alu_src1_sel_t;
    typedef enum logic [1:0] {RS2V, IMM, PC_INC} alu_src2_sel_t;
    typedef enum logic [1:0] {ZERO, ALU_RESULT, ALU_CLOCKED, MEM_RD} result_sel_t;
    typedef enum logic [2:0] {ADD_OP, SLT_OP, SLTU_OP, SRC2_OP, FUNCT_DEFINED} alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
endpackage

module mc_control_fsm
    import mc_control_pkg::*;
#(
    parameter int unsigned BUS_HANDSHAKE = 1,
    parameter int unsigned MEM_LATENCY   = 1,
    parameter int unsigned TIMEOUT       = 15,
    parameter int unsigned ILLEGAL_TRAP  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            mem_ready,
    input  logic            stall,
    output logic            mem_req,
    output logic            mem_wren,
    output logic            inst_en,
    output logic            pc_update,
    output logic            reg_wren,
    output logic            branch,
    output mem_addr_sel_t   mem_addr_sel,
    output mem_funct3_sel_t mem_funct3_sel,
    output alu_src1_sel_t   alu_src1_sel,
    output alu_src2_sel_t   alu_src2_sel,
    output result_sel_t     result_sel,
    output alu_op_t         alu_op,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [3:0]      state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FETCH_DONE, S_DECODE, S_MEM_ADDR, S_EXEC_R, S_EXEC_I,
        S_EXEC_LUI, S_MEM_READ, S_MEM_WRITE, S_MEM_WB, S_ALU_WB, S_BRANCH,
        S_JUMP, S_SETTLE, S_TRAP
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

    // Counter value on the cycle that completes a fixed-latency wait.
    localparam logic [7:0] LAT_LAST    = 8'(MEM_LATENCY - 1);
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

    state_t     state, state_next;
    logic [1:0] cause_q, cause_next;
    logic [7:0] wait_cnt;
    logic [8:0] cnt_plus;
    logic       wait_done, wait_timeout, enter_wait;
    logic       unused_funct3;

    // Only funct3[1] matters to this unit (signed vs unsigned compare).
    assign unused_funct3 = ^{funct3[2], funct3[0]};

    // cnt_plus counts the current request cycle as well, so the N-th
    // consecutive request cycle sees cnt_plus == N.
    assign cnt_plus  = {1'b0, wait_cnt} + 9'd1;
    assign wait_done = mem_req && ((BUS_HANDSHAKE != 0) ? mem_ready : (wait_cnt == LAT_LAST));
    // Completion in the same cycle beats the watchdog.
    assign wait_timeout = (BUS_HANDSHAKE != 0) && (TIMEOUT != 0) && mem_req && !wait_done &&
                          (cnt_plus >= TIMEOUT_LIM);
    assign enter_wait = (state_next != state) &&
                        ((state_next == S_FETCH) || (state_next == S_MEM_READ) ||
                         (state_next == S_MEM_WRITE));

    // State and trap-cause registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
        end
    end

    // Wait-state counter: cleared on entry, counts request cycles, saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (enter_wait) begin
            wait_cnt <= '0;
        end else if (mem_req && (wait_cnt != 8'hFF)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Next-state and trap-cause selection.
    always_comb begin
        state_next = state;
        cause_next = cause_q;
        case (state)
            S_IDLE:       state_next = S_FETCH;
            S_FETCH: begin
                if (wait_done) begin
                    state_next = S_FETCH_DONE;
                end else if (wait_timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_FETCH_DONE: state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_next = S_EXEC_R;
                    OP_I:               state_next = S_EXEC_I;
                    OP_LUI:             state_next = S_EXEC_LUI;
                    OP_AUIPC:           state_next = S_ALU_WB;
                    OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
                    OP_BRANCH:          state_next = S_BRANCH;
                    OP_JAL, OP_JALR:    state_next = S_JUMP;
                    default: begin
                        if (ILLEGAL_TRAP != 0) begin
                            state_next = S_TRAP;
                            cause_next = CAUSE_ILLEGAL;
                        end else begin
                            state_next = S_SETTLE;
                        end
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_STORE) state_next = S_MEM_WRITE;
                else                    state_next = S_MEM_READ;
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_JUMP: state_next = S_ALU_WB;
            S_MEM_READ: begin
                if (wait_done) begin
                    state_next = S_MEM_WB;
                end else if (wait_timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_MEM_WRITE: begin
                if (wait_done) begin
                    state_next = S_SETTLE;
                end else if (wait_timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_BRANCH:                     state_next = S_SETTLE;
            S_MEM_WB, S_ALU_WB, S_SETTLE: state_next = S_FETCH;
            S_TRAP:                       state_next = S_TRAP;
        endcase
    end

    // Moore decode of the registered state into datapath controls.
    always_comb begin
        mem_req        = 1'b0;
        mem_wren       = 1'b0;
        inst_en        = 1'b0;
        pc_update      = 1'b0;
        reg_wren       = 1'b0;
        branch         = 1'b0;
        mem_addr_sel   = ADDR_PC;
        mem_funct3_sel = FETCH_INST;
        alu_src1_sel   = RS1V;
        alu_src2_sel   = RS2V;
        result_sel     = ZERO;
        alu_op         = ADD_OP;
        trap           = 1'b0;
        trap_cause     = cause_q;
        state_dbg      = state;
        case (state)
            S_FETCH: mem_req = !stall;
            S_FETCH_DONE: begin
                inst_en      = 1'b1;
                pc_update    = 1'b1;
                alu_src1_sel = PC;
                alu_src2_sel = PC_INC;
                result_sel   = ALU_RESULT;
            end
            S_DECODE: begin
                if (opcode == OP_JALR) alu_src1_sel = RS1V;
                else                   alu_src1_sel = PC_OLD;
                alu_src2_sel = IMM;
            end
            S_MEM_ADDR: alu_src2_sel = IMM;
            S_EXEC_R:   alu_op = FUNCT_DEFINED;
            S_EXEC_I: begin
                alu_src2_sel = IMM;
                alu_op       = FUNCT_DEFINED;
            end
            S_EXEC_LUI: begin
                alu_src2_sel = IMM;
                alu_op       = SRC2_OP;
            end
            S_MEM_READ, S_MEM_WRITE: begin
                mem_req        = 1'b1;
                mem_wren       = (state == S_MEM_WRITE);
                mem_addr_sel   = ADDR_RESULT;
                mem_funct3_sel = MEM_FUNCT_DEFINED;
                result_sel     = ALU_CLOCKED;
            end
            S_BRANCH: begin
                if (funct3[1]) alu_op = SLTU_OP;
                else           alu_op = SLT_OP;
                branch     = 1'b1;
                result_sel = ALU_CLOCKED;
            end
            S_MEM_WB: begin
                result_sel = MEM_RD;
                reg_wren   = 1'b1;
            end
            S_ALU_WB: begin
                result_sel = ALU_CLOCKED;
                reg_wren   = 1'b1;
            end
            S_JUMP: begin
                alu_src1_sel = PC_OLD;
                alu_src2_sel = PC_INC;
                result_sel   = ALU_CLOCKED;
                pc_update    = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm. Instance a: handshake bus, TIMEOUT=4,
// illegal opcodes trap. Instance b: fixed 3-cycle latency, illegal -> NOP.
module tb_mc_control_fsm;
    import mc_control_pkg::*;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_FD = 4'd2, ST_DEC = 4'd3;
    localparam logic [3:0] ST_MADDR = 4'd4, ST_EXR = 4'd5, ST_EXI = 4'd6, ST_LUI = 4'd7;
    localparam logic [3:0] ST_MRD = 4'd8, ST_MWR = 4'd9, ST_MWB = 4'd10, ST_AWB = 4'd11;
    localparam logic [3:0] ST_BR = 4'd12, ST_JMP = 4'd13, ST_SETTLE = 4'd14, ST_TRAP = 4'd15;
    localparam bit A = 1'b0, B = 1'b1;

    logic       clk, reset, mem_ready, stall;
    logic [6:0] opcode;
    logic [2:0] funct3;

    logic a_mem_req, a_mem_wren, a_inst_en, a_pc_update, a_reg_wren, a_branch, a_trap;
    logic [1:0] a_trap_cause;
    logic [3:0] a_state_dbg;
    mem_addr_sel_t a_mem_addr_sel;  mem_funct3_sel_t a_mem_funct3_sel;
    alu_src1_sel_t a_alu_src1_sel;  alu_src2_sel_t a_alu_src2_sel;
    result_sel_t   a_result_sel;    alu_op_t a_alu_op;

    logic b_mem_req, b_mem_wren, b_inst_en, b_pc_update, b_reg_wren, b_branch, b_trap;
    logic [1:0] b_trap_cause;
    logic [3:0] b_state_dbg;
    mem_addr_sel_t b_mem_addr_sel;  mem_funct3_sel_t b_mem_funct3_sel;
    alu_src1_sel_t b_alu_src1_sel;  alu_src2_sel_t b_alu_src2_sel;
    result_sel_t   b_result_sel;    alu_op_t b_alu_op;

    mc_control_fsm #(.BUS_HANDSHAKE(1), .MEM_LATENCY(1), .TIMEOUT(4), .ILLEGAL_TRAP(1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .stall(stall), .mem_req(a_mem_req), .mem_wren(a_mem_wren), .inst_en(a_inst_en),
        .pc_update(a_pc_update), .reg_wren(a_reg_wren), .branch(a_branch),
        .mem_addr_sel(a_mem_addr_sel), .mem_funct3_sel(a_mem_funct3_sel),
        .alu_src1_sel(a_alu_src1_sel), .alu_src2_sel(a_alu_src2_sel),
        .result_sel(a_result_sel), .alu_op(a_alu_op), .trap(a_trap),
        .trap_cause(a_trap_cause), .state_dbg(a_state_dbg));

    mc_control_fsm #(.BUS_HANDSHAKE(0), .MEM_LATENCY(3), .TIMEOUT(15), .ILLEGAL_TRAP(0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .stall(stall), .mem_req(b_mem_req), .mem_wren(b_mem_wren), .inst_en(b_inst_en),
        .pc_update(b_pc_update), .reg_wren(b_reg_wren), .branch(b_branch),
        .mem_addr_sel(b_mem_addr_sel), .mem_funct3_sel(b_mem_funct3_sel),
        .alu_src1_sel(b_alu_src1_sel), .alu_src2_sel(b_alu_src2_sel),
        .result_sel(b_result_sel), .alu_op(b_alu_op), .trap(b_trap),
        .trap_cause(b_trap_cause), .state_dbg(b_state_dbg));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed bundle: state, req, wren, reg_wren, trap, cause, result_sel.
    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       wren;
        logic       regw;
        logic       trp;
        logic [1:0] cause;
        logic [1:0] rsel;
    } obs_t;

    typedef struct {
        bit    which;
        string tag;
        obs_t  exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check_front();
        sb_t  e;
        obs_t obs;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb_q.pop_front();
        if (e.which == B)
            obs = {b_state_dbg, b_mem_req, b_mem_wren, b_reg_wren, b_trap, b_trap_cause, b_result_sel};
        else
            obs = {a_state_dbg, a_mem_req, a_mem_wren, a_reg_wren, a_trap, a_trap_cause, a_result_sel};
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed st=%0d req=%b wren=%b regw=%b trap=%b cause=%0d rsel=%0d expected st=%0d req=%b wren=%b regw=%b trap=%b cause=%0d rsel=%0d",
                   e.tag, obs.st, obs.req, obs.wren, obs.regw, obs.trp, obs.cause, obs.rsel,
                   e.exp.st, e.exp.req, e.exp.wren, e.exp.regw, e.exp.trp, e.exp.cause, e.exp.rsel);
        end
    endtask

    // Drive one cycle of inputs, queue what the chosen instance must show in
    // that cycle, compare on the falling edge, then move past the next rise.
    task automatic step(input string tag, input bit which, input logic rdy, input logic stl,
                        input logic [3:0] st, input logic req, input logic wren, input logic regw,
                        input logic trp, input logic [1:0] cause, input logic [1:0] rsel);
        sb_t e;
        mem_ready = rdy;
        stall     = stl;
        e.which   = which;
        e.tag     = tag;
        e.exp     = {st, req, wren, regw, trp, cause, rsel};
        sb_q.push_back(e);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; stall = 1'b0; opcode = 7'd0; funct3 = 3'd0;

        // Reset state of both instances
        step("rst_a", A, 0, 0, ST_IDLE, 0, 0, 0, 0, 2'd0, ZERO);
        step("rst_b", B, 0, 0, ST_IDLE, 0, 0, 0, 0, 2'd0, ZERO);
        check_val("rst_sel_defaults", {a_mem_addr_sel, a_mem_funct3_sel, a_alu_src1_sel, a_alu_src2_sel, a_alu_op},
                  {ADDR_PC, FETCH_INST, RS1V, RS2V, ADD_OP});
        reset = 1'b1;

        // ADD, zero-wait
        opcode = OP_R;
        step("idle", A, 1, 0, ST_IDLE, 0, 0, 0, 0, 2'd0, ZERO);
        step("add_fetch", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        check_val("fd_strobes", {a_inst_en, a_pc_update}, 8'd3);
        step("add_fd", A, 1, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("add_dec", A, 1, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        step("add_exr", A, 1, 0, ST_EXR, 0, 0, 0, 0, 2'd0, ZERO);
        step("add_awb", A, 1, 0, ST_AWB, 0, 0, 1, 0, 2'd0, ALU_CLOCKED);

        // LW with 3 wait cycles; completion on the 4th request ties the watchdog
        opcode = OP_LOAD;
        step("lw_fetch", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("lw_fd", A, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("lw_dec", A, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        step("lw_maddr", A, 0, 0, ST_MADDR, 0, 0, 0, 0, 2'd0, ZERO);
        check_val("lw_addr_sel", a_mem_addr_sel, ADDR_RESULT);
        step("lw_wait1", A, 0, 0, ST_MRD, 1, 0, 0, 0, 2'd0, ALU_CLOCKED);
        step("lw_wait2", A, 0, 0, ST_MRD, 1, 0, 0, 0, 2'd0, ALU_CLOCKED);
        step("lw_wait3", A, 0, 0, ST_MRD, 1, 0, 0, 0, 2'd0, ALU_CLOCKED);
        step("lw_done", A, 1, 0, ST_MRD, 1, 0, 0, 0, 2'd0, ALU_CLOCKED);
        step("lw_mwb", A, 0, 0, ST_MWB, 0, 0, 1, 0, 2'd0, MEM_RD);

        // Branch, unsigned compare
        opcode = OP_BRANCH; funct3 = 3'b110;
        step("br_fetch", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("br_fd", A, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("br_dec", A, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        check_val("br_op_strobe", {a_branch, 4'd0, a_alu_op}, {1'b1, 4'd0, SLTU_OP});
        step("br_br", A, 0, 0, ST_BR, 0, 0, 0, 0, 2'd0, ALU_CLOCKED);
        step("br_settle", A, 0, 0, ST_SETTLE, 0, 0, 0, 0, 2'd0, ZERO);

        // AUIPC skips execute
        opcode = OP_AUIPC;
        step("auipc_fetch", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("auipc_fd", A, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("auipc_dec", A, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        step("auipc_awb", A, 0, 0, ST_AWB, 0, 0, 1, 0, 2'd0, ALU_CLOCKED);

        // JALR
        opcode = OP_JALR;
        step("jalr_fetch", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("jalr_fd", A, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        check_val("jalr_dec_src", {a_alu_src1_sel, a_alu_src2_sel}, {RS1V, IMM});
        step("jalr_dec", A, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        check_val("jump_pc_update", {a_pc_update, a_alu_src1_sel}, {1'b1, PC_OLD});
        step("jalr_jump", A, 0, 0, ST_JMP, 0, 0, 0, 0, 2'd0, ALU_CLOCKED);
        step("jalr_awb", A, 0, 0, ST_AWB, 0, 0, 1, 0, 2'd0, ALU_CLOCKED);

        // I-type after a 5-cycle stall (ready high but no request issued)
        opcode = OP_I;
        for (int i = 0; i < 5; i++)
            step("stall_fetch", A, 1, 1, ST_FETCH, 0, 0, 0, 0, 2'd0, ZERO);
        step("i_fetch_w", A, 0, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("i_fetch_d", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("i_fd", A, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("i_dec", A, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        step("i_exi", A, 0, 0, ST_EXI, 0, 0, 0, 0, 2'd0, ZERO);
        step("i_awb", A, 0, 0, ST_AWB, 0, 0, 1, 0, 2'd0, ALU_CLOCKED);

        // SW with one wait cycle, then SW that times out after 4 cycles
        opcode = OP_STORE;
        step("sw_fetch", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("sw_fd", A, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("sw_dec", A, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        step("sw_maddr", A, 0, 0, ST_MADDR, 0, 0, 0, 0, 2'd0, ZERO);
        step("sw_wait", A, 0, 0, ST_MWR, 1, 1, 0, 0, 2'd0, ALU_CLOCKED);
        step("sw_done", A, 1, 0, ST_MWR, 1, 1, 0, 0, 2'd0, ALU_CLOCKED);
        step("sw_settle", A, 1, 0, ST_SETTLE, 0, 0, 0, 0, 2'd0, ZERO);
        step("swto_fetch", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("swto_fd", A, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("swto_dec", A, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        step("swto_maddr", A, 0, 0, ST_MADDR, 0, 0, 0, 0, 2'd0, ZERO);
        for (int i = 0; i < 4; i++)
            step("swto_wait", A, 0, 0, ST_MWR, 1, 1, 0, 0, 2'd0, ALU_CLOCKED);
        for (int i = 0; i < 3; i++)
            step("swto_trap", A, 1, 0, ST_TRAP, 0, 0, 0, 1, 2'd2, ZERO);

        // Reset clears the trap; then reset asserted in the middle of a write
        reset = 1'b0;
        step("trap_rst", A, 0, 0, ST_IDLE, 0, 0, 0, 0, 2'd0, ZERO);
        reset = 1'b1;
        step("rw_idle", A, 0, 0, ST_IDLE, 0, 0, 0, 0, 2'd0, ZERO);
        step("rw_fetch", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("rw_fd", A, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("rw_dec", A, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        step("rw_maddr", A, 0, 0, ST_MADDR, 0, 0, 0, 0, 2'd0, ZERO);
        check_val("rw_in_write", {a_state_dbg, a_mem_req, a_mem_wren}, {ST_MWR, 2'b11});
        #2 reset = 1'b0;
        #1;
        check_val("rw_async_rst", {a_state_dbg, a_mem_req, a_mem_wren, a_mem_addr_sel}, {ST_IDLE, 3'b000});
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Illegal opcode traps with cause 1
        opcode = 7'b1111111;
        step("ill_idle", A, 0, 0, ST_IDLE, 0, 0, 0, 0, 2'd0, ZERO);
        step("ill_fetch", A, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("ill_fd", A, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("ill_dec", A, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        step("ill_trap1", A, 1, 0, ST_TRAP, 0, 0, 0, 1, 2'd1, ZERO);
        step("ill_trap2", A, 1, 0, ST_TRAP, 0, 0, 0, 1, 2'd1, ZERO);

        // Instance b: fixed latency 3, illegal opcode retires as NOP
        reset = 1'b0;
        step("b_rst", B, 0, 0, ST_IDLE, 0, 0, 0, 0, 2'd0, ZERO);
        reset = 1'b1;
        step("b_idle", B, 0, 0, ST_IDLE, 0, 0, 0, 0, 2'd0, ZERO);
        for (int i = 0; i < 3; i++)
            step("b_fetch_lat", B, 0, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("b_fd", B, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("b_dec", B, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        step("b_settle", B, 0, 0, ST_SETTLE, 0, 0, 0, 0, 2'd0, ZERO);
        opcode = OP_LUI;
        for (int i = 0; i < 3; i++)
            step("b_fetch_rdy", B, 1, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);
        step("b_lui_fd", B, 0, 0, ST_FD, 0, 0, 0, 0, 2'd0, ALU_RESULT);
        step("b_lui_dec", B, 0, 0, ST_DEC, 0, 0, 0, 0, 2'd0, ZERO);
        check_val("b_lui_op", {a_trap, 4'd0, b_alu_op}, {1'b1, 4'd0, SRC2_OP});
        step("b_lui_ex", B, 0, 0, ST_LUI, 0, 0, 0, 0, 2'd0, ZERO);
        step("b_lui_awb", B, 0, 0, ST_AWB, 0, 0, 1, 0, 2'd0, ALU_CLOCKED);
        step("b_next_fetch", B, 0, 0, ST_FETCH, 1, 0, 0, 0, 2'd0, ZERO);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
